// File: rtl/label_pkg.sv
// rtl/label_pkg.sv - shared types and constants for the label equivalence table
// Purpose: label type, background label constant and the equivalence FSM state encoding.
// Ports: none (package).
package label_pkg;

  localparam int LABEL_WIDTH = 8;

  typedef logic [LABEL_WIDTH-1:0] label_t;

  localparam label_t BG_LABEL = '0;

  typedef enum logic {
    EQ_ACCUM   = 1'b0,
    EQ_FLATTEN = 1'b1
  } eq_state_t;

endpackage

// File: rtl/label_parent_table.sv
// rtl/label_parent_table.sv - parent-pointer storage, 3 async read ports, 1 sync write port
// Purpose: flop array holding one parent label per label index.
// Ports:
//   clk                      clock
//   i_rd_a_addr/o_rd_a_data  read port A (merge operand A / flatten entry)
//   i_rd_b_addr/o_rd_b_data  read port B (merge operand B / flatten grandparent)
//   i_lk_addr/o_lk_data      read port for the lookup path
//   i_we/i_waddr/i_wdata     synchronous write port
module label_parent_table
  import label_pkg::*;
#(
  parameter int LABEL_WIDTH = 8,
  parameter int NUM_LABELS  = 2**LABEL_WIDTH
) (
  input  logic                   clk,
  input  logic [LABEL_WIDTH-1:0] i_rd_a_addr,
  output logic [LABEL_WIDTH-1:0] o_rd_a_data,
  input  logic [LABEL_WIDTH-1:0] i_rd_b_addr,
  output logic [LABEL_WIDTH-1:0] o_rd_b_data,
  input  logic [LABEL_WIDTH-1:0] i_lk_addr,
  output logic [LABEL_WIDTH-1:0] o_lk_data,
  input  logic                   i_we,
  input  logic [LABEL_WIDTH-1:0] i_waddr,
  input  logic [LABEL_WIDTH-1:0] i_wdata
);

  // Contents are never reset: every entry is rewritten when its label is allocated.
  logic [LABEL_WIDTH-1:0] r_parent [NUM_LABELS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_parent[i_waddr] <= i_wdata;
    end
  end

  assign o_rd_a_data = r_parent[i_rd_a_addr];
  assign o_rd_b_data = r_parent[i_rd_b_addr];
  assign o_lk_data   = r_parent[i_lk_addr];

endmodule

// File: rtl/label_equiv_table.sv
// rtl/label_equiv_table.sv - label allocation/merge table with end-of-frame flatten
// Purpose: applies label allocations and merges during the pixel stream, flattens the
//   parent table at frame end, and serves registered final-label lookups.
// Ports: clk, rst (sync, active-high), enable, last_in_frame, new_label_valid/value,
//   merge_labels/merge_a/merge_b, lookup_label -> resolved_label, table_valid,
//   flatten_busy, frame_done, max_label, overflow, protocol_err.
// Option: LABEL_EQUIV_STATS_EN adds num_components and merge_count outputs.
module label_equiv_table
  import label_pkg::*;
#(
  parameter int LABEL_WIDTH = label_pkg::LABEL_WIDTH,
  parameter int NUM_LABELS  = 2**LABEL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   last_in_frame,
  input  logic                   new_label_valid,
  input  logic [LABEL_WIDTH-1:0] new_label_value,
  input  logic                   merge_labels,
  input  logic [LABEL_WIDTH-1:0] merge_a,
  input  logic [LABEL_WIDTH-1:0] merge_b,
  input  logic [LABEL_WIDTH-1:0] lookup_label,
  output logic [LABEL_WIDTH-1:0] resolved_label,
  output logic                   table_valid,
  output logic                   flatten_busy,
  output logic                   frame_done,
  output logic [LABEL_WIDTH-1:0] max_label,
  output logic                   overflow,
  output logic                   protocol_err
`ifdef LABEL_EQUIV_STATS_EN
  ,
  output logic [LABEL_WIDTH:0]   num_components,
  output logic [15:0]            merge_count
`endif
);

  eq_state_t              r_state, w_state_next;
  logic [LABEL_WIDTH-1:0] r_idx, r_max_label, r_resolved;
  logic                   r_table_valid, r_frame_done, r_overflow, r_protocol_err;
  logic                   r_frame_end;  // a frame has completed; next allocation starts a new one

  logic [LABEL_WIDTH-1:0] w_rd_a_addr, w_rd_b_addr, w_rd_a, w_rd_b, w_lk_data;
  logic                   w_we;
  logic [LABEL_WIDTH-1:0] w_waddr, w_wdata;
  logic                   w_done;

  wire w_accum   = (r_state == EQ_ACCUM);
  wire w_alloc   = enable && new_label_valid && w_accum;
  wire w_merge_q = enable && merge_labels && w_accum;
  wire w_end     = enable && last_in_frame && w_accum;
  wire w_clear   = w_alloc && r_frame_end;

  wire [LABEL_WIDTH-1:0] w_max_cur = w_clear ? BG_LABEL : r_max_label;
  wire w_alloc_ok = w_alloc && (new_label_value != BG_LABEL);
  // An allocation that does not move past the current maximum means the label counter wrapped.
  wire w_wrap     = w_alloc_ok && (new_label_value <= w_max_cur);
  wire [LABEL_WIDTH-1:0] w_max_next = w_alloc_ok ? new_label_value : w_max_cur;

  wire w_merge_in_range = (merge_a != BG_LABEL) && (merge_b != BG_LABEL) &&
                          (merge_a <= r_max_label) && (merge_b <= r_max_label);
  wire w_merge_ok      = w_merge_q && !w_alloc && w_merge_in_range;
  wire w_merge_applied = w_merge_ok && (w_rd_a != w_rd_b);
  wire w_err = (w_merge_q && (w_alloc || !w_merge_in_range)) ||
               (enable && !w_accum && (new_label_valid || merge_labels));

  // During flatten port B reads the grandparent: parent[parent[idx]].
  assign w_rd_a_addr = w_accum ? merge_a : r_idx;
  assign w_rd_b_addr = w_accum ? merge_b : w_rd_a;

  label_parent_table #(
    .LABEL_WIDTH (LABEL_WIDTH),
    .NUM_LABELS  (NUM_LABELS)
  ) u_table (
    .clk         (clk),
    .i_rd_a_addr (w_rd_a_addr),
    .o_rd_a_data (w_rd_a),
    .i_rd_b_addr (w_rd_b_addr),
    .o_rd_b_data (w_rd_b),
    .i_lk_addr   (lookup_label),
    .o_lk_data   (w_lk_data),
    .i_we        (w_we),
    .i_waddr     (w_waddr),
    .i_wdata     (w_wdata)
  );

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_we         = 1'b0;
    w_waddr      = r_idx;
    w_wdata      = w_rd_b;
    case (r_state)
      EQ_ACCUM: begin
        if (w_alloc_ok) begin
          w_we    = 1'b1;
          w_waddr = new_label_value;
          w_wdata = new_label_value;
        end else if (w_merge_applied) begin
          // The larger root is re-pointed at the smaller one, keeping parent[i] <= i.
          w_we = 1'b1;
          if (w_rd_a < w_rd_b) begin
            w_waddr = w_rd_b;
            w_wdata = w_rd_a;
          end else begin
            w_waddr = w_rd_a;
            w_wdata = w_rd_b;
          end
        end
        if (w_end) begin
          if (w_max_next == BG_LABEL) begin
            w_done = 1'b1;
          end else begin
            w_state_next = EQ_FLATTEN;
          end
        end
      end
      EQ_FLATTEN: begin
        w_we = 1'b1;
        if (r_idx == r_max_label) begin
          w_done       = 1'b1;
          w_state_next = EQ_ACCUM;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= EQ_ACCUM;
      r_idx          <= '0;
      r_max_label    <= '0;
      r_resolved     <= '0;
      r_table_valid  <= 1'b0;
      r_frame_done   <= 1'b0;
      r_overflow     <= 1'b0;
      r_protocol_err <= 1'b0;
      r_frame_end    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_idx          <= w_accum ? LABEL_WIDTH'(1) : r_idx + 1'b1;
      r_max_label    <= w_max_next;
      r_resolved     <= (lookup_label == BG_LABEL) ? BG_LABEL : w_lk_data;
      r_frame_done   <= w_done;
      r_overflow     <= (r_overflow && !w_clear) || (w_alloc && !w_alloc_ok) || w_wrap;
      r_protocol_err <= (r_protocol_err && !w_clear) || w_err;
      if (w_done) begin
        r_table_valid <= 1'b1;
      end else if (w_alloc || w_merge_ok) begin
        r_table_valid <= 1'b0;
      end
      if (w_done) begin
        r_frame_end <= 1'b1;
      end else if (w_clear) begin
        r_frame_end <= 1'b0;
      end
    end
  end

`ifdef LABEL_EQUIV_STATS_EN
  logic [LABEL_WIDTH:0] r_num_components;
  logic [15:0]          r_merge_count;

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_num_components <= '0;
      r_merge_count    <= '0;
    end else begin
      if (w_end) begin
        r_num_components <= '0;
      end else if (!w_accum && (w_rd_a == r_idx)) begin
        // Roots are the only entries that point at themselves.
        r_num_components <= r_num_components + 1'b1;
      end
      if (w_merge_applied && (r_merge_count != 16'hFFFF)) begin
        r_merge_count <= r_merge_count + 16'd1;
      end
    end
  end

  assign num_components = r_num_components;
  assign merge_count    = r_merge_count;
`endif

  assign resolved_label = r_resolved;
  assign table_valid    = r_table_valid;
  assign flatten_busy   = (r_state == EQ_FLATTEN);
  assign frame_done     = r_frame_done;
  assign max_label      = r_max_label;
  assign overflow       = r_overflow;
  assign protocol_err   = r_protocol_err;

endmodule

// File: tb/tb_label_equiv_table.sv
// tb/tb_label_equiv_table.sv - directed vector bench for label_equiv_table
module tb_label_equiv_table;

  logic       clk = 1'b0;
  logic       rst, enable, last_in_frame, new_label_valid, merge_labels;
  logic [7:0] new_label_value, merge_a, merge_b, lookup_label;
  logic [7:0] resolved_label, max_label;
  logic       table_valid, flatten_busy, frame_done, overflow, protocol_err;
`ifdef LABEL_EQUIV_STATS_EN
  logic [8:0]  num_components;
  logic [15:0] merge_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  label_equiv_table #(.LABEL_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .last_in_frame   (last_in_frame),
    .new_label_valid (new_label_valid),
    .new_label_value (new_label_value),
    .merge_labels    (merge_labels),
    .merge_a         (merge_a),
    .merge_b         (merge_b),
    .lookup_label    (lookup_label),
    .resolved_label  (resolved_label),
    .table_valid     (table_valid),
    .flatten_busy    (flatten_busy),
    .frame_done      (frame_done),
    .max_label       (max_label),
    .overflow        (overflow),
    .protocol_err    (protocol_err)
`ifdef LABEL_EQUIV_STATS_EN
    ,
    .num_components  (num_components),
    .merge_count     (merge_count)
`endif
  );

  // inputs: en lif nv nval mg ma mb lk | expected after the edge: res tv busy done max ovf perr
  typedef struct {
    int en, lif, nv, nval, mg, ma, mb, lk;
    int res, tv, busy, done, mx, ovf, perr;
  } vec_t;

  vec_t tbl[$];
  int   row = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drv(input int en, input int lif, input int nv, input int nval,
                     input int mg, input int ma, input int mb, input int lk);
    enable          = en[0];
    last_in_frame   = lif[0];
    new_label_valid = nv[0];
    new_label_value = nval[7:0];
    merge_labels    = mg[0];
    merge_a         = ma[7:0];
    merge_b         = mb[7:0];
    lookup_label    = lk[7:0];
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int res, input int tv, input int busy,
                         input int done, input int mx, input int ovf, input int perr);
    chk({tag, " resolved"}, int'(resolved_label), res);
    chk({tag, " table_valid"}, int'(table_valid), tv);
    chk({tag, " busy"}, int'(flatten_busy), busy);
    chk({tag, " frame_done"}, int'(frame_done), done);
    chk({tag, " max_label"}, int'(max_label), mx);
    chk({tag, " overflow"}, int'(overflow), ovf);
    chk({tag, " protocol_err"}, int'(protocol_err), perr);
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      drv(tbl[i].en, tbl[i].lif, tbl[i].nv, tbl[i].nval, tbl[i].mg, tbl[i].ma, tbl[i].mb, tbl[i].lk);
      chk_all($sformatf("row%0d", row), tbl[i].res, tbl[i].tv, tbl[i].busy, tbl[i].done,
              tbl[i].mx, tbl[i].ovf, tbl[i].perr);
      row++;
    end
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // empty frame right after reset
    tbl.push_back('{1,1,0,0,0,0,0,0, 0,1,0,1,0,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0});
    // case 1: alloc 1,2,3; merge(1,3); three flatten cycles
    tbl.push_back('{1,0,1,1,0,0,0,0, 0,0,0,0,1,0,0});
    tbl.push_back('{1,0,1,2,0,0,0,0, 0,0,0,0,2,0,0});
    tbl.push_back('{1,0,1,3,0,0,0,0, 0,0,0,0,3,0,0});
    tbl.push_back('{1,0,0,0,1,1,3,0, 0,0,0,0,3,0,0});
    tbl.push_back('{1,1,0,0,0,0,0,3, 1,0,1,0,3,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,3, 1,0,1,0,3,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,3, 1,0,1,0,3,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,2, 2,1,0,1,3,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,3, 1,1,0,0,3,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,1, 1,1,0,0,3,0,0});
    run_table();
`ifdef LABEL_EQUIV_STATS_EN
    chk("case1 num_components", int'(num_components), 2);
    chk("case1 merge_count", int'(merge_count), 1);
`endif

    // case 2: chain merge, four flatten cycles
    tbl.push_back('{1,0,1,1,0,0,0,0, 0,0,0,0,1,0,0});
    tbl.push_back('{1,0,1,2,0,0,0,0, 0,0,0,0,2,0,0});
    tbl.push_back('{1,0,1,3,0,0,0,0, 0,0,0,0,3,0,0});
    tbl.push_back('{1,0,1,4,0,0,0,0, 0,0,0,0,4,0,0});
    tbl.push_back('{1,0,0,0,1,3,4,0, 0,0,0,0,4,0,0});
    tbl.push_back('{1,0,0,0,1,2,3,0, 0,0,0,0,4,0,0});
    tbl.push_back('{1,0,0,0,1,1,2,0, 0,0,0,0,4,0,0});
    tbl.push_back('{1,1,0,0,0,0,0,4, 3,0,1,0,4,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,1,0,4,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,1,0,4,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,1,0,4,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,1, 1,1,0,1,4,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,2, 1,1,0,0,4,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,3, 1,1,0,0,4,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,4, 1,1,0,0,4,0,0});
    // case 3: allocation and merge in the same cycle
    tbl.push_back('{1,0,1,1,0,0,0,0, 0,0,0,0,1,0,0});
    tbl.push_back('{1,0,1,2,0,0,0,0, 0,0,0,0,2,0,0});
    tbl.push_back('{1,0,1,3,1,1,2,0, 0,0,0,0,3,0,1});
    tbl.push_back('{0,0,0,0,0,0,0,2, 2,0,0,0,3,0,1});
    tbl.push_back('{1,1,0,0,0,0,0,0, 0,0,1,0,3,0,1});
    tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,1,0,3,0,1});
    tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,1,0,3,0,1});
    tbl.push_back('{0,0,0,0,0,0,0,2, 2,1,0,1,3,0,1});
    tbl.push_back('{0,0,0,0,0,0,0,3, 3,1,0,0,3,0,1});
    // allocation of label 0 and out-of-range merge; new frame clears the sticky flags
    tbl.push_back('{1,0,1,1,0,0,0,0, 0,0,0,0,1,0,0});
    tbl.push_back('{1,0,1,0,0,0,0,0, 0,0,0,0,1,1,0});
    tbl.push_back('{1,0,0,0,1,1,9,0, 0,0,0,0,1,1,1});
    tbl.push_back('{1,1,0,0,0,0,0,1, 1,0,1,0,1,1,1});
    tbl.push_back('{0,0,0,0,0,0,0,1, 1,1,0,1,1,1,1});
    // case 4: merge and allocation requests during flatten are dropped
    tbl.push_back('{1,0,1,1,0,0,0,0, 0,0,0,0,1,0,0});
    tbl.push_back('{1,0,1,2,0,0,0,0, 0,0,0,0,2,0,0});
    tbl.push_back('{1,0,0,0,1,1,2,0, 0,0,0,0,2,0,0});
    tbl.push_back('{1,1,0,0,0,0,0,2, 1,0,1,0,2,0,0});
    tbl.push_back('{1,0,0,0,1,1,2,0, 0,0,1,0,2,0,1});
    tbl.push_back('{1,0,1,5,0,0,0,0, 0,1,0,1,2,0,1});
    tbl.push_back('{0,0,0,0,0,0,0,2, 1,1,0,0,2,0,1});
    tbl.push_back('{0,0,0,0,0,0,0,1, 1,1,0,0,2,0,1});
    run_table();

    // case 6: reset in the middle of a 50-label flatten
    for (int i = 1; i <= 50; i++) drv(1, 0, 1, i, 0, 0, 0, 0);
    chk("c6 max before flatten", int'(max_label), 50);
    drv(1, 1, 0, 0, 0, 0, 0, 5);
    for (int i = 0; i < 10; i++) drv(1, 0, 0, 0, (i == 3) ? 1 : 0, 1, 2, 5);
    chk("c6 busy before rst", int'(flatten_busy), 1);
    chk("c6 perr before rst", int'(protocol_err), 1);
    chk("c6 resolved before rst", int'(resolved_label), 5);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 5);
    chk_all("c6 rst", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drv(1, 0, 1, 1, 0, 0, 0, 0);
    drv(1, 0, 1, 2, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 1, 1, 2, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    chk("c6 refill busy", int'(flatten_busy), 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 2);
    chk("c6 refill done", int'(frame_done), 1);
    chk("c6 refill resolved 2", int'(resolved_label), 1);
    chk("c6 refill max", int'(max_label), 2);
    chk("c6 refill perr", int'(protocol_err), 0);
`ifdef LABEL_EQUIV_STATS_EN
    chk("c6 num_components", int'(num_components), 1);
    chk("c6 merge_count", int'(merge_count), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
